// File: rtl/overlap_energy.sv
// Seam-finder front end: per-pixel energy over the overlap of two images.
// D = |a-b|; cost = 2*D + |D - Dleft| + |D - Dup|, one result per accepted pair.
module overlap_energy #(
    parameter int OVERLAPWIDTH  = 300,
    parameter int OVERLAPHEIGHT = 1100
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  pix_a,
    input  logic [7:0]  pix_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] cost,
    output logic [15:0] out_col,
    output logic [15:0] out_row,
    output logic        out_eol,
    output logic        out_eof,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam int          AW       = (OVERLAPWIDTH > 1) ? $clog2(OVERLAPWIDTH) : 1;
    localparam logic [15:0] LAST_COL = 16'(OVERLAPWIDTH - 1);
    localparam logic [15:0] LAST_ROW = 16'(OVERLAPHEIGHT - 1);

    state_t      state_q, state_d;
    logic [15:0] col_q, col_d, row_q, row_d;
    logic [7:0]  dleft_q, dleft_d;
    logic        out_valid_q, out_valid_d;
    logic [9:0]  cost_q, cost_d;
    logic [15:0] out_col_q, out_col_d, out_row_q, out_row_d;
    logic        out_eol_q, out_eol_d, out_eof_q, out_eof_d;
    logic        done_q, done_d;

    // Previous row's D per column; never reset, row 0 never reads it.
    logic [7:0]  lbuf_q [OVERLAPWIDTH];

    logic [AW-1:0] col_idx;
    logic          xfer, last_col, last_pix;
    logic [7:0]    d, d_left, d_up, ad_left, ad_up;
    logic [9:0]    cost_nxt;

    assign col_idx  = col_q[AW-1:0];
    assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
    assign xfer     = in_valid && in_ready;
    assign last_col = (col_q == LAST_COL);
    assign last_pix = last_col && (row_q == LAST_ROW);

    // Energy datapath; the line buffer is read here before this pair's write lands.
    always_comb begin
        d        = (pix_a >= pix_b) ? (pix_a - pix_b) : (pix_b - pix_a);
        d_left   = (col_q == 16'd0) ? d : dleft_q;
        d_up     = (row_q == 16'd0) ? d : lbuf_q[col_idx];
        ad_left  = (d >= d_left) ? (d - d_left) : (d_left - d);
        ad_up    = (d >= d_up) ? (d - d_up) : (d_up - d);
        cost_nxt = {1'b0, d, 1'b0} + {2'b00, ad_left} + {2'b00, ad_up};
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        dleft_d = dleft_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    col_d   = 16'd0;
                    row_d   = 16'd0;
                    dleft_d = 8'd0;
                end
            end
            RUN: begin
                if (xfer) begin
                    dleft_d = d;
                    if (last_col) begin
                        col_d = 16'd0;
                        row_d = row_q + 16'd1;
                        if (last_pix) state_d = FLUSH;
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                end
            end
            FLUSH: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: loads on every transfer-in, drains only when taken.
    always_comb begin
        out_valid_d = out_valid_q;
        cost_d      = cost_q;
        out_col_d   = out_col_q;
        out_row_d   = out_row_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            cost_d      = cost_nxt;
            out_col_d   = col_q;
            out_row_d   = row_q;
            out_eol_d   = last_col;
            out_eof_d   = last_pix;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= 16'd0;
            row_q       <= 16'd0;
            dleft_q     <= 8'd0;
            out_valid_q <= 1'b0;
            cost_q      <= 10'd0;
            out_col_q   <= 16'd0;
            out_row_q   <= 16'd0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            dleft_q     <= dleft_d;
            out_valid_q <= out_valid_d;
            cost_q      <= cost_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (xfer) lbuf_q[col_idx] <= d;
    end

    assign out_valid = out_valid_q;
    assign cost      = {22'd0, cost_q};
    assign out_col   = out_col_q;
    assign out_row   = out_row_q;
    assign out_eol   = out_eol_q;
    assign out_eof   = out_eof_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_overlap_energy.sv
// Randomised bench for overlap_energy on a 4x3 overlap, checked against a
// frame-level energy model built from the arithmetic definition of the cost.
module tb_overlap_energy;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  pix_a = 8'd0;
    logic [7:0]  pix_b = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] cost;
    logic [15:0] out_col, out_row;
    logic        out_eol, out_eof, busy, done;

    int npass = 0;
    int ntot  = 0;
    int pa [N];
    int pb [N];
    logic [65:0] got [$];

    always #5 sys_clk = ~sys_clk;

    overlap_energy #(.OVERLAPWIDTH(W), .OVERLAPHEIGHT(H)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .pix_a(pix_a), .pix_b(pix_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .cost(cost), .out_col(out_col), .out_row(out_row),
        .out_eol(out_eol), .out_eof(out_eof),
        .busy(busy), .done(done)
    );

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int dval(input int i);
        return iabs(pa[i] - pb[i]);
    endfunction

    // Expected {cost, col, row, eol, eof} of the i-th pixel in raster order.
    function automatic logic [65:0] exp_out(input int i);
        int col, row, dv, dl, du, c;
        col = i % W;
        row = i / W;
        dv  = dval(i);
        dl  = (col == 0) ? dv : dval(i - 1);
        du  = (row == 0) ? dv : dval(i - W);
        c   = 2 * dv + iabs(dv - dl) + iabs(dv - du);
        return {32'(c), 16'(col), 16'(row), (col == W - 1), (i == N - 1)};
    endfunction

    function automatic logic [65:0] cur_out();
        return {cost, out_col, out_row, out_eol, out_eof};
    endfunction

    task automatic rand_image();
        for (int i = 0; i < N; i++) begin
            pa[i] = int'($urandom_range(255));
            pb[i] = int'($urandom_range(255));
        end
    endtask

    // Drives one frame with random handshakes and collects every taken output.
    task automatic run_frame(input int iv_pct, input int or_pct, input int stall_at,
                             input int stall_len, input int start_at,
                             output bit timeout, output bit stall_ok);
        int idx = 0;
        int cyc = 0;
        bit stalling;
        logic [65:0] held = '0;
        got.delete();
        stall_ok = 1'b1;
        start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        while (got.size() < N && cyc < 2000) begin
            stalling  = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            in_valid  = (idx < N) && (stalling || int'($urandom_range(99)) < iv_pct);
            pix_a     = 8'(pa[(idx < N) ? idx : N - 1]);
            pix_b     = 8'(pb[(idx < N) ? idx : N - 1]);
            out_ready = !stalling && (int'($urandom_range(99)) < or_pct);
            start     = (cyc == start_at);
            @(negedge sys_clk);
            if (stalling) begin
                if (cyc == stall_at) held = cur_out();
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || cur_out() !== held) stall_ok = 1'b0;
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) got.push_back(cur_out());
            @(posedge sys_clk); #1;
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        timeout = (got.size() < N);
    endtask

    task automatic test_reset();
        #2;
        ntot++;
        if ({in_ready, out_valid, out_eol, out_eof, busy, done, cost, out_col, out_row} !== '0)
            $display("FAIL reset_async got %b/%b/%h expected all zero", busy, out_valid, cost);
        else npass++;
        repeat (2) @(posedge sys_clk);
        #1;
        ntot++;
        if ({in_ready, out_valid, busy, done, cost} !== '0)
            $display("FAIL reset_clocked got busy=%b ov=%b cost=%h expected 0", busy, out_valid, cost);
        else npass++;
        rst_n = 1'b1;
        @(posedge sys_clk); #1;
        ntot++;
        if (busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL idle_after_reset got busy=%b in_ready=%b expected 0", busy, in_ready);
        else npass++;
    endtask

    task automatic test_uniform();
        bit to, so;
        for (int i = 0; i < N; i++) begin pa[i] = 50; pb[i] = 50; end
        run_frame(100, 100, -1, 0, -1, to, so);
        ntot++;
        if (to) $display("FAIL uniform_count got %0d outputs expected %0d", got.size(), N);
        else npass++;
        for (int i = 0; i < N; i++) begin
            logic [65:0] g;
            g = (i < got.size()) ? got[i] : 'x;
            ntot++;
            if (g !== exp_out(i)) $display("FAIL uniform[%0d] got %h expected %h", i, g, exp_out(i));
            else npass++;
        end
        ntot++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL uniform_done got done=%b busy=%b expected 1/0", done, busy);
        else npass++;
        @(posedge sys_clk); #1;
        ntot++;
        if (done !== 1'b0) $display("FAIL uniform_done_pulse got %b expected 0", done);
        else npass++;
    endtask

    task automatic test_gradient();
        bit to, so;
        for (int i = 0; i < N; i++) begin pa[i] = (i < W) ? 10 : 40; pb[i] = 0; end
        run_frame(100, 100, -1, 0, -1, to, so);
        for (int i = 0; i < N; i++) begin
            logic [65:0] g;
            g = (i < got.size()) ? got[i] : 'x;
            ntot++;
            if (g !== exp_out(i)) $display("FAIL gradient[%0d] got %h expected %h", i, g, exp_out(i));
            else npass++;
        end
        ntot++;
        if (to || got[0][65:34] !== 32'd20 || got[4][65:34] !== 32'd110 || got[7][65:34] !== 32'd110)
            $display("FAIL gradient_const got %0d/%0d/%0d expected 20/110/110",
                     got[0][65:34], got[4][65:34], got[7][65:34]);
        else npass++;
    endtask

    task automatic test_worst();
        bit to, so;
        for (int i = 0; i < N; i++) begin pa[i] = (i == W) ? 255 : 0; pb[i] = 0; end
        run_frame(100, 100, -1, 0, -1, to, so);
        for (int i = 0; i < N; i++) begin
            logic [65:0] g;
            g = (i < got.size()) ? got[i] : 'x;
            ntot++;
            if (g !== exp_out(i)) $display("FAIL worst[%0d] got %h expected %h", i, g, exp_out(i));
            else npass++;
        end
        ntot++;
        if (to || got[W][65:34] !== 32'd765 || got[W+1][65:34] !== 32'd255)
            $display("FAIL worst_const got %0d/%0d expected 765/255", got[W][65:34], got[W+1][65:34]);
        else npass++;
    endtask

    task automatic test_stall();
        bit to, so;
        rand_image();
        run_frame(100, 100, 5, 5, -1, to, so);
        ntot++;
        if (!so) $display("FAIL stall_hold got unstable output or in_ready=1 expected held");
        else npass++;
        ntot++;
        if (to) $display("FAIL stall_count got %0d outputs expected %0d", got.size(), N);
        else npass++;
        for (int i = 0; i < N; i++) begin
            logic [65:0] g;
            g = (i < got.size()) ? got[i] : 'x;
            ntot++;
            if (g !== exp_out(i)) $display("FAIL stall[%0d] got %h expected %h", i, g, exp_out(i));
            else npass++;
        end
    endtask

    task automatic test_midreset();
        bit to, so;
        rand_image();
        start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            pix_a = 8'(pa[k]);
            pix_b = 8'(pb[k]);
            @(posedge sys_clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        ntot++;
        if ({in_ready, out_valid, out_eol, out_eof, busy, done, cost, out_col, out_row} !== '0)
            $display("FAIL midreset_async got busy=%b ov=%b cost=%h col=%h expected 0",
                     busy, out_valid, cost, out_col);
        else npass++;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        ntot++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL midreset_idle got busy=%b in_ready=%b ov=%b expected 0", busy, in_ready, out_valid);
        else npass++;
        rand_image();
        run_frame(100, 100, -1, 0, -1, to, so);
        for (int i = 0; i < N; i++) begin
            logic [65:0] g;
            g = (i < got.size()) ? got[i] : 'x;
            ntot++;
            if (g !== exp_out(i)) $display("FAIL midreset_frame[%0d] got %h expected %h", i, g, exp_out(i));
            else npass++;
        end
    endtask

    task automatic test_start_in_run();
        bit to, so;
        rand_image();
        run_frame(80, 80, -1, 0, 4, to, so);
        ntot++;
        if (to || busy !== 1'b0 || done !== 1'b1)
            $display("FAIL restart_end got n=%0d busy=%b done=%b expected %0d/0/1", got.size(), busy, done, N);
        else npass++;
        for (int i = 0; i < N; i++) begin
            logic [65:0] g;
            g = (i < got.size()) ? got[i] : 'x;
            ntot++;
            if (g !== exp_out(i)) $display("FAIL restart[%0d] got %h expected %h", i, g, exp_out(i));
            else npass++;
        end
    endtask

    task automatic test_random();
        bit to, so;
        for (int f = 0; f < 4; f++) begin
            rand_image();
            run_frame(60, 60, -1, 0, -1, to, so);
            ntot++;
            if (to) $display("FAIL random_count[%0d] got %0d expected %0d", f, got.size(), N);
            else npass++;
            for (int i = 0; i < N; i++) begin
                logic [65:0] g;
                g = (i < got.size()) ? got[i] : 'x;
                ntot++;
                if (g !== exp_out(i)) $display("FAIL random[%0d][%0d] got %h expected %h", f, i, g, exp_out(i));
                else npass++;
            end
            repeat (2) @(posedge sys_clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_gradient();
        test_worst();
        test_stall();
        test_midreset();
        test_start_in_run();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/overlap_energy.md
OVERLAP_ENERGY -- requirements
Module: overlap_energy

Interface
REQ-001 SHALL have parameter OVERLAPWIDTH, default 300, meaning pixels per overlap row.
REQ-002 SHALL have parameter OVERLAPHEIGHT, default 1100, meaning rows per overlap frame.
REQ-003 SHALL have port sys_clk, input, 1, meaning the single clock (rising edge); one clock, no other clock domains.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, meaning a one-cycle frame-start request.
REQ-006 SHALL have port in_valid, input, 1, meaning pix_a/pix_b are valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts a pixel pair this cycle.
REQ-008 SHALL have ports pix_a and pix_b, input, 8 each, meaning the grey pixel of the left and right image at the same overlap position.
REQ-009 SHALL have port out_valid, output, 1, meaning cost and the tags are valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the downstream seam-finder takes the output.
REQ-011 SHALL have port cost, output, 32, meaning the pixel energy, zero-extended.
REQ-012 SHALL have ports out_col and out_row, output, 16 each, meaning the coordinates of the cost.
REQ-013 SHALL have port out_eol, output, 1, meaning out_col == OVERLAPWIDTH-1.
REQ-014 SHALL have port out_eof, output, 1, meaning the last pixel of the frame.
REQ-015 SHALL have ports busy and done, output, 1 each, meaning a frame is in progress and a one-cycle frame-complete pulse respectively.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and FLUSH: IDLE->RUN on start; RUN->FLUSH when pixel (OVERLAPHEIGHT-1, OVERLAPWIDTH-1) is accepted; FLUSH->IDLE when the last output is taken (out_valid && out_ready).
REQ-017 SHALL ignore start in RUN and FLUSH.
REQ-018 SHALL define transfer-in as in_valid && in_ready, with in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-019 SHALL advance col by 1 per transfer-in, and on col==OVERLAPWIDTH-1 wrap col to 0 and increment row.
REQ-020 SHALL zero row and col on IDLE->RUN.
REQ-021 SHALL compute D = |pix_a - pix_b| as an 8-bit unsigned value.
REQ-022 SHALL compute cost = 2*D + |D - Dleft| + |D - Dup|, at most 1020 (10 bits), zero-extended to 32 bits, with no wrap.
REQ-023 SHALL take Dleft as D of the previous pixel in the same row, or D itself when col==0.
REQ-024 SHALL take Dup from a line buffer of OVERLAPWIDTH x 8-bit entries holding the previous row's D, or D itself when row==0.
REQ-025 SHALL read the line buffer at entry col before writing D to it on the same transfer-in (read-before-write).
REQ-026 SHALL have latency 1: the result of a transfer-in at edge k is presented with out_valid=1 after edge k.
REQ-027 SHALL hold out_valid, cost and the tags stable while out_valid && !out_ready.
REQ-028 SHALL load the new result on the same edge when out_ready and a transfer-in coincide, keeping out_valid=1 (no bubble).
REQ-029 SHALL clear out_valid when out_ready is high and there is no transfer-in.
REQ-030 SHALL drive busy = (state != IDLE).
REQ-031 SHALL pulse done for exactly one cycle, on the cycle after the FLUSH->IDLE transition edge.
REQ-032 SHALL drive out_eof=1 only with the tag pair (OVERLAPHEIGHT-1, OVERLAPWIDTH-1).
REQ-033 SHALL stall indefinitely, losing no data, when in_valid is low mid-row.

Reset
REQ-034 SHALL, while rst_n is low and regardless of sys_clk, force state to IDLE, row, col and Dleft to 0, and in_ready, out_valid, out_eol, out_eof, busy and done to 0, with cost, out_col and out_row at 0.
REQ-035 SHALL not reset the line-buffer contents, which must never be read before being written in the current frame (row 0 uses D).
REQ-036 SHALL, on rst_n asserted mid-frame, abandon the frame and remain IDLE after release until a new start.

Verification
REQ-037 SHALL verify (OVERLAPWIDTH=4, OVERLAPHEIGHT=3) start then 12 pairs a=b=50 with out_ready=1 -> 12 outputs with cost=0, out_eol on cols 3, out_eof on the 12th output, done one cycle after the last output is taken.
REQ-038 SHALL verify row 0 a=10,b=0 in all four pairs -> cost 20,20,20,20; then row 1 a=40,b=0 in all four pairs -> cost 80+0+30=110 at col 0 and 80+0+30=110 at cols 1-3.
REQ-039 SHALL verify worst case row 0 D=0, row 1 a=255,b=0 at col 0 -> cost 510+0+255=765; then col 1 with D=0 and Dup=0 -> cost 0+255+0=255.
REQ-040 SHALL verify out_ready=0 for 5 cycles mid-row with in_valid=1 -> in_ready=0 and output held constant; on release the stream resumes with no loss or duplication.
REQ-041 SHALL verify rst_n pulsed low during row 1 -> all outputs 0 immediately (asynchronous); then start produces a fresh frame with row-0 costs computed from D alone.
REQ-042 SHALL verify start pulsed during RUN -> counters unaffected and frame completes normally.
